fir_resampler_decim_stage: RTL and testbench
============================================

# fir_resampler_decim_stage

Runtime-configurable decimation back end for the FIR resampler chain. It takes the channel-interleaved sample stream from the polyphase interpolator and keeps one frame in every `dec_r` frames, at a programmable phase. Kept samples are tagged with their channel index and buffered in a small first-word-fall-through FIFO with a ready/valid output. It replaces fixed-ratio, single-channel, no-backpressure decimation.

## Interface
Parameters:
- `CHANNELS`, 1: interleaved channels per frame.
- `DATA_WIDTH`, 16: sample width, signed.
- `MAX_DECIMATION`, 32: largest supported ratio.
- `FIFO_DEPTH`, 8: output FIFO depth; power of two, ≥2.
- `DEC_WIDTH`, `$clog2(MAX_DECIMATION+1)`: ratio/phase field width.
- `CH_WIDTH`, `CHANNELS>1 ? $clog2(CHANNELS) : 1`: channel index width.
- `LVL_WIDTH`, `$clog2(FIFO_DEPTH+1)`: FIFO level width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `data_i` in DATA_WIDTH: input sample, signed.
- `data_val_i` in 1: input valid. No backpressure; every valid cycle is one sample.
- `cfg_dec_i` in DEC_WIDTH: requested decimation ratio.
- `cfg_phase_i` in DEC_WIDTH: requested keep phase.
- `cfg_load_i` in 1: one-cycle request to apply `cfg_dec_i`/`cfg_phase_i`.
- `data_o` out DATA_WIDTH: FIFO head sample.
- `data_ch_o` out CH_WIDTH: channel index of the head sample.
- `data_val_o` out 1: FIFO not empty.
- `data_rdy_i` in 1: downstream ready; pop happens on `data_val_o && data_rdy_i`.
- `fifo_level_o` out LVL_WIDTH: FIFO occupancy.
- `ovf_o` out 1: sticky overflow flag.
- `ovf_clr_i` in 1: clears `ovf_o`.

## Operation
- **Channel counter** `ch_cnt`:
  - Increments on each `data_val_i`.
  - Wraps from CHANNELS-1 to 0.
  - A frame completes when `data_val_i` arrives with `ch_cnt == CHANNELS-1`.
- **Frame counter** `dec_cnt`:
  - Increments on each frame completion.
  - Wraps from `dec_r`-1 to 0.
- **Keep rule:**
  - A sample is kept if `dec_cnt == phase_r` when it arrives.
  - All CHANNELS samples of that frame are kept.
  - A kept sample is pushed to the FIFO as {`ch_cnt`, `data_i`}.
- **Configuration:**
  - `cfg_load_i` sets `cfg_pend` and captures both fields into shadow registers.
  - A second load before apply overwrites the shadow.
  - Pending config applies at the next frame boundary. That is either the cycle of a frame completion, or any cycle with `ch_cnt == 0` and `data_val_i` low, including the cycle after the load.
  - On apply:
    - `dec_r` = clamp(shadow ratio): 0→1, >MAX_DECIMATION→MAX_DECIMATION.
    - `phase_r` = shadow phase, or `dec_r`-1 if phase ≥ `dec_r`.
    - `dec_cnt` ← 0.
    - `cfg_pend` ← 0.
  - If apply coincides with a frame completion, the new config governs the next frame. The completing frame's keep decision uses the old config.
- **FIFO:**
  - Registered storage with FWFT output.
  - Push while full without a pop in the same cycle: the sample is dropped, `ovf_o` sets, and counters advance normally.
  - Push while full with a simultaneous pop: both happen and the level is unchanged.
  - Pop while empty is ignored.
- **Overflow flag:** `ovf_clr_i` clears `ovf_o`. If set and clear occur in the same cycle, set wins.
- **Reset values:**
  - `ch_cnt`, `dec_cnt`, `cfg_pend`, FIFO pointers, level: 0.
  - `dec_r` = 1, `phase_r` = 0 (pass-through).
  - `data_o`, `data_ch_o`: 0.
  - `data_val_o`, `ovf_o`, `fifo_level_o`: 0.

## Timing
- Latency from a kept `data_val_i` at cycle N into an empty FIFO: `data_val_o` high with that sample at cycle N+1.
- After a pop at cycle N, the next entry is presented at N+1.
- `fifo_level_o` reflects the push/pop of cycle N at N+1.
- `cfg_load_i` at cycle N with the block idle (`ch_cnt` = 0, no valid at N+1): config is active from N+2.
- Reset asserted mid-operation: all state returns to reset values asynchronously. The FIFO contents are discarded and pending config is lost.
- Throughput: one sample per clock in, one per clock out.

## Test plan
- **Pass-through after reset:** CHANNELS=1, 10 consecutive samples 1..10, `data_rdy_i`=1 → outputs 1..10, each one cycle after input, `ovf_o`=0.
- **Decimation with phase:** CHANNELS=2, load dec=4 phase=1, feed frames {k, 100+k} for k=0..11 → outputs frames 1, 5, 9 as (1,ch0), (101,ch1), (5,ch0), (105,ch1), (9,ch0), (109,ch1).
- **Clamping:** load dec=0 → every frame kept. Load dec=40 phase=50 with MAX=32 → `dec_r`=32, `phase_r`=31; only frame 31 of 64 frames and frame 63 kept.
- **Mid-frame load:** CHANNELS=3, dec=2; assert `cfg_load_i` (dec=3) after channel 0 of a frame → the current frame still follows dec=2, and the new ratio starts at the next frame with `dec_cnt`=0.
- **Backpressure and overflow:** FIFO_DEPTH=4, `data_rdy_i`=0, pass-through, 6 samples → level 4, samples 5–6 dropped, `ovf_o`=1. Then raise ready → outputs 1..4. Pulse `ovf_clr_i` → `ovf_o`=0.
- **Full push+pop and async reset:** at level 4 push and pop in the same cycle → level stays 4 and order is preserved. Assert `rst_i` mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/fir_resampler_decim_stage.sv
// Decimating back end: keeps one frame in every dec_r frames at phase_r, tags kept
// samples with their channel index and queues them in a first-word-fall-through FIFO.
module fir_resampler_decim_stage #(
   parameter int CHANNELS       = 1,
   parameter int DATA_WIDTH     = 16,
   parameter int MAX_DECIMATION = 32,
   parameter int FIFO_DEPTH     = 8,
   parameter int DEC_WIDTH      = $clog2(MAX_DECIMATION + 1),
   parameter int CH_WIDTH       = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
   parameter int LVL_WIDTH      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic signed [DATA_WIDTH-1:0] data_i,
   input  logic                         data_val_i,
   input  logic [DEC_WIDTH-1:0]         cfg_dec_i,
   input  logic [DEC_WIDTH-1:0]         cfg_phase_i,
   input  logic                         cfg_load_i,
   output logic signed [DATA_WIDTH-1:0] data_o,
   output logic [CH_WIDTH-1:0]          data_ch_o,
   output logic                         data_val_o,
   input  logic                         data_rdy_i,
   output logic [LVL_WIDTH-1:0]         fifo_level_o,
   output logic                         ovf_o,
   input  logic                         ovf_clr_i
);
   localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
   localparam logic [CH_WIDTH-1:0]  CH_LAST  = CH_WIDTH'(CHANNELS - 1);
   localparam logic [DEC_WIDTH-1:0] DEC_MAX  = DEC_WIDTH'(MAX_DECIMATION);
   localparam logic [DEC_WIDTH-1:0] DEC_ONE  = DEC_WIDTH'(1);
   localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);

   typedef struct packed {
      logic [CH_WIDTH-1:0]   ch;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   logic [CH_WIDTH-1:0]  ch_cnt;
   logic [DEC_WIDTH-1:0] dec_cnt, dec_r, phase_r;
   logic [DEC_WIDTH-1:0] sh_dec, sh_phase, dec_new, phase_new;
   logic                 cfg_pend, frame_done, keep, apply;
   logic                 push, pop, full;
   logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [LVL_WIDTH-1:0] level;
   logic                 ovf;
   entry_t               mem [FIFO_DEPTH];
   entry_t               head;

   always_comb begin
      frame_done = data_val_i && (ch_cnt == CH_LAST);
      keep       = data_val_i && (dec_cnt == phase_r);
      // Idle slot at a frame edge is also a safe point to swap configuration.
      apply      = cfg_pend && (frame_done || (ch_cnt == '0 && !data_val_i));
      dec_new    = sh_dec;
      if (sh_dec == '0)
         dec_new = DEC_ONE;
      else if (sh_dec > DEC_MAX)
         dec_new = DEC_MAX;
      phase_new  = (sh_phase >= dec_new) ? dec_new - DEC_ONE : sh_phase;
      full       = (level == LVL_FULL);
      pop        = (level != '0) && data_rdy_i;
      push       = keep && (!full || pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ch_cnt   <= '0;
         dec_cnt  <= '0;
         dec_r    <= DEC_ONE;
         phase_r  <= '0;
         sh_dec   <= '0;
         sh_phase <= '0;
         cfg_pend <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ovf      <= 1'b0;
      end else begin
         if (data_val_i)
            ch_cnt <= frame_done ? '0 : ch_cnt + CH_WIDTH'(1);
         // The completing frame already took its keep decision with the old config.
         if (apply) begin
            dec_r   <= dec_new;
            phase_r <= phase_new;
            dec_cnt <= '0;
         end else if (frame_done) begin
            dec_cnt <= (dec_cnt == dec_r - DEC_ONE) ? '0 : dec_cnt + DEC_ONE;
         end
         if (cfg_load_i) begin
            sh_dec   <= cfg_dec_i;
            sh_phase <= cfg_phase_i;
            cfg_pend <= 1'b1;
         end else if (apply) begin
            cfg_pend <= 1'b0;
         end
         if (push)
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         level <= level + LVL_WIDTH'(push) - LVL_WIDTH'(pop);
         if (keep && !push)
            ovf <= 1'b1;
         else if (ovf_clr_i)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr] <= '{ch: ch_cnt, data: data_i};
   end

   assign head         = mem[rd_ptr];
   assign data_val_o   = (level != '0);
   assign data_o       = data_val_o ? head.data : '0;
   assign data_ch_o    = data_val_o ? head.ch : '0;
   assign fifo_level_o = level;
   assign ovf_o        = ovf;

endmodule

// File: tb/tb_fir_resampler_decim_stage.sv
// Directed bench for fir_resampler_decim_stage: two channels, depth-4 FIFO,
// expected output stream queued by hand and compared at every pop.
module tb_fir_resampler_decim_stage;
   localparam int CH   = 2;
   localparam int DW   = 16;
   localparam int MAXD = 32;
   localparam int FD   = 4;
   localparam int DECW = $clog2(MAXD + 1);
   localparam int CHW  = 1;
   localparam int LVLW = $clog2(FD + 1);

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic [DW-1:0]   data_i = '0;
   logic            data_val_i = 1'b0;
   logic [DECW-1:0] cfg_dec_i = '0;
   logic [DECW-1:0] cfg_phase_i = '0;
   logic            cfg_load_i = 1'b0;
   logic [DW-1:0]   data_o;
   logic [CHW-1:0]  data_ch_o;
   logic            data_val_o;
   logic            data_rdy_i = 1'b0;
   logic [LVLW-1:0] fifo_level_o;
   logic            ovf_o;
   logic            ovf_clr_i = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic mch = 1'b0;
   logic [CHW+DW-1:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   fir_resampler_decim_stage #(
      .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_DECIMATION(MAXD), .FIFO_DEPTH(FD)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .data_val_i(data_val_i),
      .cfg_dec_i(cfg_dec_i), .cfg_phase_i(cfg_phase_i), .cfg_load_i(cfg_load_i),
      .data_o(data_o), .data_ch_o(data_ch_o), .data_val_o(data_val_o),
      .data_rdy_i(data_rdy_i), .fifo_level_o(fifo_level_o), .ovf_o(ovf_o),
      .ovf_clr_i(ovf_clr_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check any pop happening at the coming edge.
   task automatic cyc(input logic v, input logic [DW-1:0] d);
      logic [CHW+DW-1:0] e;
      data_val_i = v;
      data_i     = d;
      if (data_val_o && data_rdy_i) begin
         if (exp_q.size() == 0) begin
            chk("out_extra", 32'(data_val_o), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out", 32'({data_ch_o, data_o}), 32'(e));
         end
      end
      if (v) mch = mch + 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic kept);
      if (kept) exp_q.push_back({mch, d});
      cyc(1'b1, d);
   endtask

   task automatic load(input int dec, input int ph);
      cfg_dec_i   = DECW'(dec);
      cfg_phase_i = DECW'(ph);
      cfg_load_i  = 1'b1;
      cyc(1'b0, '0);
      cfg_load_i  = 1'b0;
      cyc(1'b0, '0);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, '0);
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_val", 32'(data_val_o), 0);
      chk("rst_data", 32'(data_o), 0);
      chk("rst_ch", 32'(data_ch_o), 0);
      chk("rst_level", 32'(fifo_level_o), 0);
      chk("rst_ovf", 32'(ovf_o), 0);
      rst_i = 1'b0;

      // pass-through: each sample appears the cycle after it enters
      data_rdy_i = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         send(16'(k), 1'b1);
         chk("pt_val", 32'(data_val_o), 1);
         chk("pt_level", 32'(fifo_level_o), 1);
      end
      idle(1);
      chk("pt_drain", 32'(fifo_level_o), 0);
      chk("pt_ovf", 32'(ovf_o), 0);
      chk("pt_left", exp_q.size(), 0);

      // dec=4 phase=1: frames 1, 5, 9 kept
      load(4, 1);
      for (int k = 0; k < 12; k++) begin
         send(16'(k), k % 4 == 1);
         send(16'(100 + k), k % 4 == 1);
      end
      idle(2);
      chk("dec_left", exp_q.size(), 0);

      // dec=0 clamps to 1; dec=40/phase=50 clamp to 32/31
      load(0, 0);
      for (int k = 0; k < 3; k++) begin
         send(16'(200 + k), 1'b1);
         send(16'(300 + k), 1'b1);
      end
      load(40, 50);
      for (int k = 0; k < 64; k++) begin
         send(16'(1000 + k), k == 31 || k == 63);
         send(16'(2000 + k), k == 31 || k == 63);
      end
      idle(2);
      chk("clamp_left", exp_q.size(), 0);

      // load after ch0 of frame 0 under dec=2/phase=1: applies after frame 1
      load(2, 1);
      send(16'(500), 1'b0);
      cfg_dec_i = 3; cfg_phase_i = 1; cfg_load_i = 1'b1;
      send(16'(600), 1'b0);
      cfg_load_i = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         send(16'(500 + k), k == 1 || k == 3 || k == 6);
         send(16'(600 + k), k == 1 || k == 3 || k == 6);
      end
      idle(2);
      chk("mid_left", exp_q.size(), 0);
      load(1, 0);

      // backpressure: 6 samples into depth 4, last two dropped
      data_rdy_i = 1'b0;
      for (int k = 1; k <= 6; k++) send(16'(k), k <= 4);
      chk("ovf_level", 32'(fifo_level_o), 4);
      chk("ovf_flag", 32'(ovf_o), 1);
      chk("ovf_head", 32'(data_o), 1);
      data_rdy_i = 1'b1;
      send(16'(7), 1'b1);
      chk("full_pp_level", 32'(fifo_level_o), 4);
      chk("full_pp_ovf", 32'(ovf_o), 1);
      idle(4);
      chk("ovf_drain", 32'(fifo_level_o), 0);
      chk("ovf_left", exp_q.size(), 0);
      ovf_clr_i = 1'b1; cyc(1'b0, '0); ovf_clr_i = 1'b0;
      chk("ovf_clr", 32'(ovf_o), 0);

      // set beats clear in the same cycle
      data_rdy_i = 1'b0;
      for (int k = 1; k <= 4; k++) send(16'(20 + k), 1'b1);
      ovf_clr_i = 1'b1; send(16'(25), 1'b0); ovf_clr_i = 1'b0;
      chk("ovf_set_wins", 32'(ovf_o), 1);
      data_rdy_i = 1'b1;
      idle(4);
      chk("sw_left", exp_q.size(), 0);

      // async reset mid-stream with ovf still set and dec=3 active
      load(3, 0);
      data_rdy_i = 1'b0;
      send(16'(30), 1'b1); send(16'(31), 1'b1);
      send(16'(32), 1'b0); send(16'(33), 1'b0);
      chk("pre_rst_level", 32'(fifo_level_o), 2);
      chk("pre_rst_head", 32'(data_o), 30);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_val", 32'(data_val_o), 0);
      chk("arst_data", 32'(data_o), 0);
      chk("arst_ch", 32'(data_ch_o), 0);
      chk("arst_level", 32'(fifo_level_o), 0);
      chk("arst_ovf", 32'(ovf_o), 0);
      exp_q.delete();
      mch = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      data_rdy_i = 1'b1;
      for (int k = 0; k < 4; k++) send(16'(40 + k), 1'b1);
      idle(2);
      chk("post_rst_left", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
